instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 32-bit words in instruction memory (power of two).
REQ-002 Parameter AW, default 8, memory word-index width; SHALL equal log2(MEM_DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 initialize  input  1  memory load mode; fetch halted while high.
REQ-006 instruction_initialize_data  input  32  word to write in load mode.
REQ-007 instruction_initialize_address  input  32  byte address of word to write in load mode.
REQ-008 redirect_valid  input  1  downstream branch/jump redirect request, one-cycle pulse.
REQ-009 redirect_target  input  32  byte address to fetch after a redirect.
REQ-010 out_ready  input  1  downstream decode stage can accept an instruction.
REQ-011 out_valid  output  1  instruction_out/pc_out hold a valid fetched instruction.
REQ-012 instruction_out  output  32  fetched instruction word.
REQ-013 pc_out  output  32  byte address of instruction_out.

Function
REQ-014 Memory SHALL be MEM_DEPTH x 32 bits, indexed by byte address bits [AW+1:2]; higher bits ignored (aliasing); bits [1:0] ignored.
REQ-015 When initialize=1, each rising edge SHALL write instruction_initialize_data to the indexed word, regardless of rst.
REQ-016 Memory contents SHALL NOT be cleared by rst.
REQ-017 Internal register pc SHALL hold the next fetch byte address; memory read at pc is combinational.
REQ-018 Output register (out_valid, instruction_out, pc_out) SHALL load mem[pc], pc when fetch is enabled and (out_valid=0 or out_ready=1); this is the "advance" condition.
REQ-019 Fetch enabled SHALL mean rst=0 and initialize=0.
REQ-020 On advance, next pc SHALL be pc+4, except when the fetched word has opcode [31:26]=6'b000010 (J).
REQ-021 For J, next pc SHALL be pc + 4 + (sign-extended [25:0] << 2), modulo 2^32; J word itself SHALL still be issued on instruction_out.
REQ-022 Stall (out_valid=1, out_ready=0): pc and output register SHALL hold unchanged.
REQ-023 redirect_valid=1 with fetch enabled SHALL set pc <= {redirect_target[31:2],2'b00} and out_valid <= 0 on that edge, overriding REQ-018/020/022 (redirect priority over stall and J).
REQ-024 Sequence after redirect: one bubble cycle (out_valid=0), then target instruction issued next cycle.
REQ-025 pc arithmetic SHALL wrap modulo 2^32; memory index wraps modulo MEM_DEPTH.
REQ-026 When initialize=1 and rst=0: pc and output register SHALL hold; out_valid SHALL be forced 0; redirect_valid ignored.
REQ-027 Latency: instruction at address A SHALL appear on outputs one cycle after pc=A with advance true.
REQ-028 Implementation SHALL have no combinational path from out_ready or redirect_valid to any output.

Reset
REQ-029 rst=1 SHALL on the next edge set pc=0, out_valid=0, instruction_out=0, pc_out=0.
REQ-030 rst has priority over redirect_valid and advance; rst mid-stall SHALL discard the held instruction.
REQ-031 First fetch after rst and initialize both low SHALL be from address 0, issued one cycle later.

Verification
REQ-032 Load 0:0x00021020, 4:0x00021020, 8:0x0BFFFFFD with rst=initialize=1, release both, out_ready=1 -> pc_out sequence 0,4,8,0,4,8,... with out_valid=1 every cycle after the first fetch edge.
REQ-033 Same program, out_ready=0 for 3 cycles while pc_out=4 -> outputs hold 4/0x00021020 for 3 cycles, then 8 issued the cycle after out_ready rises.
REQ-034 Redirect pulse target 0x00000006 while issuing 4 -> next cycle out_valid=0, following cycle pc_out=4 (low bits cleared), then 8.
REQ-035 Redirect during stall (out_ready=0) -> held instruction dropped, bubble, target issued; no instruction duplicated.
REQ-036 rst pulsed for one cycle while pc_out=8 -> next cycle all outputs 0, then pc_out=0 issued; memory contents unchanged.
REQ-037 J at address 0 with imm26=0x3FFFFFF (-1) -> pc_out 0 repeats every cycle (self loop); write at address 0x404 with MEM_DEPTH=256 -> aliases to word 1.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-to-decode link: instruction handshake toward decode plus the redirect request from downstream.
// The fetch unit connects through the master modport and decode through the slave modport.
interface instruction_fetch_if;
   logic        out_valid;
   logic [31:0] instruction_out;
   logic [31:0] pc_out;
   logic        out_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   modport master (
      output out_valid, instruction_out, pc_out,
      input  out_ready, redirect_valid, redirect_target
   );

   modport slave (
      input  out_valid, instruction_out, pc_out,
      output out_ready, redirect_valid, redirect_target
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with a loadable word memory, a registered output and a valid/ready handshake.
// Unconditional J instructions are resolved in fetch, and a downstream redirect takes priority over stall.
module instruction_fetch #(
   parameter int MEM_DEPTH = 256,
   parameter int AW        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                initialize,
   input  logic [31:0]         instruction_initialize_data,
   input  logic [31:0]         instruction_initialize_address,
   instruction_fetch_if.master bus
);

   localparam logic [5:0] OP_J = 6'b000010;

   logic [31:0] r_mem [MEM_DEPTH];
   logic [31:0] r_pc;
   logic        r_out_valid;
   logic [31:0] r_instruction;
   logic [31:0] r_pc_out;

   logic [AW-1:0] w_fetch_idx;
   logic [AW-1:0] w_init_idx;
   logic [31:0]   w_fetch_word;
   logic [31:0]   w_jump_offset;
   logic [31:0]   w_seq_pc;
   logic [31:0]   w_next_pc;
   logic          w_fetch_en;
   logic          w_advance;
   logic          w_unused_bits;

   // Word index comes from bits [AW+1:2]; upper address bits alias onto the same words.
   assign w_fetch_idx   = r_pc[AW+1:2];
   assign w_init_idx    = instruction_initialize_address[AW+1:2];
   assign w_fetch_word  = r_mem[w_fetch_idx];
   assign w_jump_offset = {{4{w_fetch_word[25]}}, w_fetch_word[25:0], 2'b00};
   assign w_seq_pc      = r_pc + 32'd4;
   assign w_fetch_en    = !rst && !initialize;
   assign w_advance     = w_fetch_en && (!r_out_valid || bus.out_ready);
   assign w_unused_bits = ^{instruction_initialize_address[31:AW+2],
                            instruction_initialize_address[1:0],
                            bus.redirect_target[1:0]};

   // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_next_pc = w_seq_pc;
      if (w_fetch_word[31:26] == OP_J)
         w_next_pc = w_seq_pc + w_jump_offset;
   end

   // NOTE: the memory has no reset branch; its contents must survive rst, and a reset would also prevent RAM inference.
   always_ff @(posedge clk) begin
      if (initialize)
         r_mem[w_init_idx] <= instruction_initialize_data;
   end

   // Priority: rst, then load mode, then redirect, then the normal advance; anything else is a stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= 32'd0;
         r_out_valid   <= 1'b0;
         r_instruction <= 32'd0;
         r_pc_out      <= 32'd0;
      end else if (initialize) begin
         r_out_valid <= 1'b0;
      end else if (bus.redirect_valid) begin
         r_pc        <= {bus.redirect_target[31:2], 2'b00};
         r_out_valid <= 1'b0;
      end else if (w_advance) begin
         r_out_valid   <= 1'b1;
         r_instruction <= w_fetch_word;
         r_pc_out      <= r_pc;
         r_pc          <= w_next_pc;
      end
   end

   assign bus.out_valid       = r_out_valid;
   assign bus.instruction_out = r_instruction;
   assign bus.pc_out          = r_pc_out;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: the stimulus queues the expected post-edge output state,
// and an independent monitor pops and compares it shortly after each rising edge.
module tb_instruction_fetch;

   localparam logic [31:0] W_ADD  = 32'h0002_1020;
   localparam logic [31:0] W_J8   = 32'h0BFF_FFFD;  // J, imm -3: from address 8 back to 0
   localparam logic [31:0] W_JS   = 32'h0BFF_FFFF;  // J, imm -1: self loop

   typedef struct packed {
      logic        full;   // 0: only out_valid is compared
      logic        v;
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        initialize;
   logic [31:0] instruction_initialize_data;
   logic [31:0] instruction_initialize_address;

   instruction_fetch_if bus ();

   instruction_fetch #(.MEM_DEPTH(256), .AW(8)) dut (
      .clk                            (clk),
      .rst                            (rst),
      .initialize                     (initialize),
      .instruction_initialize_data    (instruction_initialize_data),
      .instruction_initialize_address (instruction_initialize_address),
      .bus                            (bus)
   );

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: one queued expectation is consumed per clock, sampled 3 time units after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (e.full) begin
               if ({bus.out_valid, bus.pc_out, bus.instruction_out} !== {e.v, e.pc, e.ins}) begin
                  n_bad++;
                  $display("FAIL outputs#%0d: got valid=%0b pc=%h instr=%h, want valid=%0b pc=%h instr=%h",
                           n_cmp, bus.out_valid, bus.pc_out, bus.instruction_out, e.v, e.pc, e.ins);
               end
            end else if (bus.out_valid !== e.v) begin
               n_bad++;
               $display("FAIL valid#%0d: got valid=%0b, want valid=%0b", n_cmp, bus.out_valid, e.v);
            end
         end
      end
   end

   // Queue the state expected after the coming edge, then cross that edge; redirect is a one-cycle pulse.
   task automatic step(input logic full, input logic v, input logic [31:0] pc, input logic [31:0] ins);
      exp_q.push_back('{full: full, v: v, pc: pc, ins: ins});
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
      step(1'b1, 1'b1, pc, ins);
   endtask

   task automatic bubble();
      step(1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic zeros();
      step(1'b1, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      instruction_initialize_address = addr;
      instruction_initialize_data    = data;
      zeros();
   endtask

   initial begin
      rst                            = 1'b1;
      initialize                     = 1'b1;
      instruction_initialize_data    = 32'd0;
      instruction_initialize_address = 32'd0;
      bus.out_ready                  = 1'b1;
      bus.redirect_valid             = 1'b0;
      bus.redirect_target            = 32'd0;

      // Program load under reset: outputs stay at their reset values.
      load(32'h0, W_ADD);
      load(32'h4, W_ADD);
      load(32'h8, W_J8);

      // Free-running loop 0,4,8 with the J at 8 jumping back to 0.
      rst        = 1'b0;
      initialize = 1'b0;
      issue(32'h0, W_ADD);
      issue(32'h4, W_ADD);
      issue(32'h8, W_J8);
      issue(32'h0, W_ADD);
      issue(32'h4, W_ADD);
      issue(32'h8, W_J8);
      issue(32'h0, W_ADD);

      // Three-cycle stall while address 4 is presented.
      issue(32'h4, W_ADD);
      bus.out_ready = 1'b0;
      repeat (3) issue(32'h4, W_ADD);
      bus.out_ready = 1'b1;
      issue(32'h8, W_J8);
      issue(32'h0, W_ADD);
      issue(32'h4, W_ADD);

      // Redirect to 0x6 while issuing 4: bubble, then 4 (low bits cleared), then 8.
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h0000_0006;
      bubble();
      issue(32'h4, W_ADD);
      issue(32'h8, W_J8);
      issue(32'h0, W_ADD);

      // Redirect to 8 during a stall: the held word at 0 is dropped.
      bus.out_ready = 1'b0;
      issue(32'h0, W_ADD);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h0000_0008;
      bubble();
      issue(32'h8, W_J8);
      issue(32'h8, W_J8);
      bus.out_ready = 1'b1;
      issue(32'h0, W_ADD);
      issue(32'h4, W_ADD);

      // Reset pulse during a stall at 8: everything clears, refetch starts at 0 from intact memory.
      issue(32'h8, W_J8);
      bus.out_ready = 1'b0;
      issue(32'h8, W_J8);
      rst = 1'b1;
      zeros();
      rst           = 1'b0;
      bus.out_ready = 1'b1;
      issue(32'h0, W_ADD);
      issue(32'h4, W_ADD);
      issue(32'h8, W_J8);

      // Load mode without reset: outputs hold but valid drops, redirect is ignored, 0x404 aliases word 1.
      initialize                     = 1'b1;
      instruction_initialize_address = 32'h0000_0404;
      instruction_initialize_data    = W_JS;
      bus.redirect_valid             = 1'b1;
      bus.redirect_target            = 32'h0000_0040;
      step(1'b1, 1'b0, 32'h8, W_J8);
      initialize = 1'b0;
      issue(32'h0, W_ADD);
      issue(32'h4, W_JS);
      issue(32'h4, W_JS);
      issue(32'h4, W_JS);

      // Self-loop J at address 0, written while rst is also high.
      rst                            = 1'b1;
      initialize                     = 1'b1;
      instruction_initialize_address = 32'h0;
      instruction_initialize_data    = W_JS;
      zeros();
      rst        = 1'b0;
      initialize = 1'b0;
      issue(32'h0, W_JS);
      issue(32'h0, W_JS);
      issue(32'h0, W_JS);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #5;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
